compute_dispatch_ctrl: RTL and testbench
========================================

COMPUTE_DISPATCH_CTRL -- requirements
Module: compute_dispatch_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENGINES, default 5, number of executor engines; op code N dispatches to engine N.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, BRAM read address width.
REQ-003 SHALL have parameter OP_WIDTH, default 3, selector op code width.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, execution cycle counter width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit in clocks.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: start  in  1  level request; sel_result_valid  in  1  selector result pulse; sel_abort  in  1  selector abort pulse; sel_result_op  in  OP_WIDTH  requested op; sel_bram_addr  in  ADDR_WIDTH  selector read address.
REQ-008 SHALL have ports: eng_start  out  NUM_ENGINES  one-hot start pulse; eng_busy  in  NUM_ENGINES  engine busy; eng_done  in  NUM_ENGINES  engine done pulse; eng_bram_addr  in  NUM_ENGINES*ADDR_WIDTH  packed engine read addresses, engine i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have ports: bram_rd_addr  out  ADDR_WIDTH  muxed read address; busy, done, error, timeout  out  1  status; active_engine  out  OP_WIDTH  latched engine index; cycle_count  out  CNT_WIDTH  execution clocks.

Function
REQ-010 SHALL implement states IDLE, SELECTING, DISPATCH, EXECUTING, DONE, ERROR.
REQ-011 SHALL go IDLE->SELECTING when start=1; on this transition error and timeout clear to 0.
REQ-012 SHALL, in SELECTING, on sel_result_valid latch sel_result_op into active_engine and go to DISPATCH if op < NUM_ENGINES, else ERROR; sel_result_valid wins over simultaneous sel_abort.
REQ-013 SHALL go SELECTING->IDLE on sel_abort without sel_result_valid.
REQ-014 SHALL, in DISPATCH, wait while eng_busy[active_engine]=1; when 0, drive eng_start[active_engine]=1 for exactly one cycle, clear cycle_count to 0, and go EXECUTING next cycle.
REQ-015 SHALL keep all other eng_start bits 0 at all times; never more than one bit high.
REQ-016 SHALL, in EXECUTING, increment cycle_count by 1 per clock, saturating at all-ones.
REQ-017 SHALL go EXECUTING->DONE on eng_done[active_engine]=1; done bits of other engines are ignored.
REQ-018 SHALL hold cycle_count and active_engine in DONE, ERROR, IDLE until next DISPATCH pulse.
REQ-019 SHALL leave DONE or ERROR to IDLE on the first cycle start=0; error and timeout stay asserted after leaving ERROR until next IDLE->SELECTING.
REQ-020 SHALL drive busy=1 in SELECTING, DISPATCH, EXECUTING; done=1 only in DONE; error=1 in ERROR and sticky per REQ-019.
REQ-021 SHALL combinationally drive bram_rd_addr from eng_bram_addr of active_engine in DISPATCH and EXECUTING, else sel_bram_addr; zero latency.
REQ-022 SHALL ignore start while not in IDLE, DONE, ERROR.

Reset
REQ-023 SHALL, when rst=1 at a clk edge, enter IDLE and set eng_start, busy, done, error, timeout, active_engine, cycle_count to 0.
REQ-024 SHALL honour reset mid-operation (any state) identically; no eng_start pulse in the reset cycle or the cycle after.

Configuration
REQ-025 SHALL, with macro COMPUTE_TIMEOUT_EN defined, go EXECUTING->ERROR with timeout=1 when cycle_count equals TIMEOUT_CYCLES-1 and eng_done[active_engine]=0; eng_done in the same cycle wins (DONE).
REQ-026 SHALL, without COMPUTE_TIMEOUT_EN, tie timeout to 0, ignore TIMEOUT_CYCLES, and wait in EXECUTING indefinitely.

Verification
REQ-027 SHALL cover: NUM_ENGINES=5, start=1, sel_result_valid with op=2, eng_done[2] 10 cycles after eng_start[2] -> one-cycle eng_start=5'b00100, DONE with cycle_count=10, done=1 until start=0.
REQ-028 SHALL cover: op=6 with NUM_ENGINES=5 -> ERROR, error=1, no eng_start bit ever high; start=0 then start=1 -> error clears on entering SELECTING.
REQ-029 SHALL cover: eng_busy[1]=1 for 4 cycles at DISPATCH with op=1 -> eng_start[1] pulses on cycle 5, bram_rd_addr equals eng_bram_addr slice 1 throughout.
REQ-030 SHALL cover: sel_abort and sel_result_valid in same cycle, op=0 -> DISPATCH taken; sel_abort alone -> IDLE, busy=0 next cycle.
REQ-031 SHALL cover: COMPUTE_TIMEOUT_EN, TIMEOUT_CYCLES=8, engine never done -> ERROR with timeout=1, cycle_count=7; same with eng_done at count 7 -> DONE, timeout=0.
REQ-032 SHALL cover: rst=1 asserted in EXECUTING -> next cycle all outputs 0, state IDLE, bram_rd_addr follows sel_bram_addr.

Source files
------------

// File: rtl/compute_dispatch_ctrl.sv
// Dispatch controller: hands a selector-chosen op to one executor engine and times its execution.
// Optional watchdog enabled by defining COMPUTE_TIMEOUT_EN.
module compute_dispatch_ctrl #(
  parameter int NUM_ENGINES    = 5,
  parameter int ADDR_WIDTH     = 14,
  parameter int OP_WIDTH       = 3,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sel_result_valid,
  input  logic                              sel_abort,
  input  logic [OP_WIDTH-1:0]               sel_result_op,
  input  logic [ADDR_WIDTH-1:0]             sel_bram_addr,
  output logic [NUM_ENGINES-1:0]            eng_start,
  input  logic [NUM_ENGINES-1:0]            eng_busy,
  input  logic [NUM_ENGINES-1:0]            eng_done,
  input  logic [NUM_ENGINES*ADDR_WIDTH-1:0] eng_bram_addr,
  output logic [ADDR_WIDTH-1:0]             bram_rd_addr,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              timeout,
  output logic [OP_WIDTH-1:0]               active_engine,
  output logic [CNT_WIDTH-1:0]              cycle_count
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SELECTING = 3'd1;
  localparam logic [2:0] ST_DISPATCH  = 3'd2;
  localparam logic [2:0] ST_EXECUTING = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  localparam logic [OP_WIDTH:0]    NUM_ENG_L = (OP_WIDTH+1)'(NUM_ENGINES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  logic [2:0]             state_r;
  logic [2:0]             next_state_s;
  logic [OP_WIDTH-1:0]    active_engine_r;
  logic [CNT_WIDTH-1:0]   cycle_count_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   error_r;
  logic                   timeout_r;
  logic                   act_busy_s;
  logic                   act_done_s;
  logic [ADDR_WIDTH-1:0]  act_addr_s;
  logic [NUM_ENGINES-1:0] act_onehot_s;
  logic                   op_valid_s;
  logic                   launch_s;
  logic                   timeout_hit_s;
  logic                   engine_phase_s;

  // Per-engine signals of the latched engine, selected by a compare loop so out-of-range ops select nothing
  always_comb begin
    act_busy_s   = 1'b0;
    act_done_s   = 1'b0;
    act_addr_s   = {ADDR_WIDTH{1'b0}};
    act_onehot_s = {NUM_ENGINES{1'b0}};
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (active_engine_r == OP_WIDTH'(i)) begin
        act_busy_s      = eng_busy[i];
        act_done_s      = eng_done[i];
        act_addr_s      = eng_bram_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        act_onehot_s[i] = 1'b1;
      end else begin
        act_onehot_s[i] = 1'b0;
      end
    end
  end

  assign op_valid_s     = ({1'b0, sel_result_op} < NUM_ENG_L);
  assign launch_s       = (state_r == ST_DISPATCH) && !act_busy_s && !rst;
  assign engine_phase_s = (state_r == ST_DISPATCH) || (state_r == ST_EXECUTING);

`ifdef COMPUTE_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  assign timeout_hit_s = (cycle_count_r == TIMEOUT_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state decode; start is only looked at from IDLE, DONE and ERROR
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_SELECTING;
        else       next_state_s = ST_IDLE;
      end
      ST_SELECTING: begin
        if (sel_result_valid) next_state_s = op_valid_s ? ST_DISPATCH : ST_ERROR;
        else if (sel_abort)   next_state_s = ST_IDLE;
        else                  next_state_s = ST_SELECTING;
      end
      ST_DISPATCH: begin
        if (launch_s) next_state_s = ST_EXECUTING;
        else          next_state_s = ST_DISPATCH;
      end
      ST_EXECUTING: begin
        if (act_done_s)         next_state_s = ST_DONE;
        else if (timeout_hit_s) next_state_s = ST_ERROR;
        else                    next_state_s = ST_EXECUTING;
      end
      ST_DONE, ST_ERROR: begin
        if (!start) next_state_s = ST_IDLE;
        else        next_state_s = state_r;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, status flags, latched engine index and execution counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      error_r         <= 1'b0;
      timeout_r       <= 1'b0;
      active_engine_r <= {OP_WIDTH{1'b0}};
      cycle_count_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_SELECTING) || (next_state_s == ST_DISPATCH) ||
                 (next_state_s == ST_EXECUTING);
      done_r  <= (next_state_s == ST_DONE);

      // error/timeout are sticky until the next request is accepted
      if ((state_r == ST_IDLE) && start) begin
        error_r   <= 1'b0;
        timeout_r <= 1'b0;
      end else if (next_state_s == ST_ERROR) begin
        error_r   <= 1'b1;
        timeout_r <= timeout_r | (state_r == ST_EXECUTING);
      end else begin
        error_r   <= error_r;
        timeout_r <= timeout_r;
      end

      if ((state_r == ST_SELECTING) && sel_result_valid) begin
        active_engine_r <= sel_result_op;
      end else begin
        active_engine_r <= active_engine_r;
      end

      // The watchdog edge freezes the count at the limit; a done edge still counts its clock
      if (launch_s) begin
        cycle_count_r <= {CNT_WIDTH{1'b0}};
      end else if ((state_r == ST_EXECUTING) && (act_done_s || !timeout_hit_s) &&
                   (cycle_count_r != CNT_MAX)) begin
        cycle_count_r <= cycle_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cycle_count_r <= cycle_count_r;
      end
    end
  end

  assign eng_start     = launch_s ? act_onehot_s : {NUM_ENGINES{1'b0}};
  assign bram_rd_addr  = engine_phase_s ? act_addr_s : sel_bram_addr;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
`ifdef COMPUTE_TIMEOUT_EN
  assign timeout       = timeout_r;
`else
  assign timeout       = 1'b0;
`endif
  assign active_engine = active_engine_r;
  assign cycle_count   = cycle_count_r;

endmodule

// File: tb/tb_compute_dispatch_ctrl.sv
// Self-checking bench for compute_dispatch_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_compute_dispatch_ctrl;

  localparam int NE = 5;
  localparam int AW = 14;
  localparam int OW = 3;
  localparam int CW = 32;
  localparam int TO = 8;
`ifdef COMPUTE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic             sel_result_valid;
  logic             sel_abort;
  logic [OW-1:0]    sel_result_op;
  logic [AW-1:0]    sel_bram_addr;
  logic [NE-1:0]    eng_start;
  logic [NE-1:0]    eng_busy;
  logic [NE-1:0]    eng_done;
  logic [NE*AW-1:0] eng_bram_addr;
  logic [AW-1:0]    bram_rd_addr;
  logic             busy;
  logic             done;
  logic             error;
  logic             timeout;
  logic [OW-1:0]    active_engine;
  logic [CW-1:0]    cycle_count;

  int n_total = 0;
  int n_pass  = 0;

  compute_dispatch_ctrl #(
    .NUM_ENGINES(NE), .ADDR_WIDTH(AW), .OP_WIDTH(OW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sel_result_valid(sel_result_valid),
    .sel_abort(sel_abort), .sel_result_op(sel_result_op), .sel_bram_addr(sel_bram_addr),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_bram_addr(eng_bram_addr), .bram_rd_addr(bram_rd_addr), .busy(busy), .done(done),
    .error(error), .timeout(timeout), .active_engine(active_engine), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addrs();
    eng_bram_addr = {6'($urandom), 32'($urandom), 32'($urandom)};
    sel_bram_addr = AW'($urandom);
  endtask

  function automatic logic [AW-1:0] slice_of(input int e);
    return AW'(eng_bram_addr >> (e * AW));
  endfunction

  // One request from start to return to IDLE. Expected outcome from the rules: done d clocks
  // after the start pulse gives DONE with count d, unless the watchdog limit is passed first.
  task automatic run_txn(input int op, input int busy_cyc, input int d, input bit abort_too);
    logic [NE-1:0] oh;
    bit            to_hit;
    int            len;
    logic [CW-1:0] exp_cnt;
    oh      = (op < NE) ? NE'(1 << op) : {NE{1'b0}};
    to_hit  = TO_EN && (op < NE) && (d > TO);
    len     = to_hit ? TO : d;
    exp_cnt = to_hit ? CW'(TO - 1) : CW'(d);

    start = 1'b1;
    rand_addrs();
    step();
    chk("sel_busy", busy, 1);
    chk("sel_error_clear", error, 0);
    chk("sel_timeout_clear", timeout, 0);
    repeat ($urandom_range(0, 2)) begin
      rand_addrs();
      #1;
      chk("sel_addr", bram_rd_addr, sel_bram_addr);
      step();
    end
    sel_result_valid = 1'b1;
    sel_result_op    = OW'(op);
    sel_abort        = abort_too;
    step();
    sel_result_valid = 1'b0;
    sel_abort        = 1'b0;
    chk("active_engine", active_engine, op);

    if (op >= NE) begin
      chk("bad_op_error", error, 1);
      chk("bad_op_busy", busy, 0);
      chk("bad_op_no_start", eng_start, 0);
      repeat (2) begin
        step();
        chk("bad_op_error_hold", error, 1);
        chk("bad_op_no_start", eng_start, 0);
      end
      start = 1'b0;
      step();
      chk("bad_op_error_sticky", error, 1);
      chk("bad_op_idle_busy", busy, 0);
      chk("bad_op_idle_done", done, 0);
      return;
    end

    chk("disp_busy", busy, 1);
    for (int k = 0; k <= busy_cyc; k++) begin
      rand_addrs();
      eng_busy = NE'($urandom) & ~oh;
      if (k < busy_cyc) eng_busy = eng_busy | oh;
      #1;
      chk("disp_addr", bram_rd_addr, slice_of(op));
      chk("disp_start", eng_start, (k == busy_cyc) ? oh : {NE{1'b0}});
      step();
    end
    eng_busy = {NE{1'b0}};

    for (int k = 1; k <= len; k++) begin
      rand_addrs();
      eng_done = NE'($urandom) & ~oh;
      if (k == d) eng_done = eng_done | oh;
      #1;
      chk("exec_no_start", eng_start, 0);
      chk("exec_addr", bram_rd_addr, slice_of(op));
      chk("exec_busy", busy, 1);
      chk("exec_count", cycle_count, k - 1);
      step();
    end
    eng_done = {NE{1'b0}};

    chk("end_count", cycle_count, exp_cnt);
    chk("end_done", done, !to_hit);
    chk("end_error", error, to_hit);
    chk("end_timeout", timeout, to_hit);
    chk("end_busy", busy, 0);
    repeat ($urandom_range(1, 3)) begin
      step();
      chk("hold_done", done, !to_hit);
      chk("hold_count", cycle_count, exp_cnt);
    end
    start = 1'b0;
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_count", cycle_count, exp_cnt);
    chk("idle_active", active_engine, op);
    chk("idle_error_sticky", error, to_hit);
    chk("idle_timeout_sticky", timeout, to_hit);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_active"}, active_engine, 0);
    chk({tag, "_count"}, cycle_count, 0);
    chk({tag, "_addr"}, bram_rd_addr, sel_bram_addr);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel_result_valid = 1'b0; sel_abort = 1'b0;
    sel_result_op = {OW{1'b0}}; eng_busy = {NE{1'b0}}; eng_done = {NE{1'b0}};
    rand_addrs();
    repeat (2) step();
    chk_reset_state("reset");
    rst = 1'b0;
    step();

    // Nominal dispatch to engine 2, done 10 clocks after its start pulse
    run_txn(2, 0, 10, 1'b0);
    // Out-of-range op, then a fresh request clears the error
    run_txn(6, 0, 1, 1'b0);
    run_txn(0, 0, 3, 1'b0);
    // Engine 1 busy for 4 dispatch cycles
    run_txn(1, 4, 5, 1'b0);
    // Result valid wins over simultaneous abort
    run_txn(0, 1, 2, 1'b1);

    // Abort alone returns to idle
    start = 1'b1;
    step();
    chk("abort_sel_busy", busy, 1);
    start = 1'b0;
    sel_abort = 1'b1;
    step();
    sel_abort = 1'b0;
    chk("abort_busy", busy, 0);
    step();
    chk("abort_stay_idle", busy, 0);

    // Never-done engine (watchdog if enabled) and done exactly at the watchdog limit
    run_txn(3, 0, 20, 1'b0);
    run_txn(4, 0, 8, 1'b0);
    run_txn(2, 2, 7, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 12)), 1'($urandom));
    end

    // Reset during DISPATCH with the engine free: no start pulse
    start = 1'b1;
    step();
    sel_result_valid = 1'b1; sel_result_op = 3'd3;
    step();
    sel_result_valid = 1'b0; start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_disp_no_start", eng_start, 0);
    step();
    rand_addrs();
    #1;
    chk_reset_state("rst_disp");
    rst = 1'b0;
    step();
    chk("rst_after_no_start", eng_start, 0);
    chk("rst_after_busy", busy, 0);

    // Reset during EXECUTING
    start = 1'b1;
    step();
    sel_result_valid = 1'b1; sel_result_op = 3'd2;
    step();
    sel_result_valid = 1'b0; start = 1'b0;
    step();
    step();
    chk("pre_rst_exec_busy", busy, 1);
    rst = 1'b1;
    step();
    rand_addrs();
    #1;
    chk_reset_state("rst_exec");
    rst = 1'b0;
    step();
    chk("rst_exec_after_start", eng_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
